c1355_resp_misr: RTL and testbench

Response compactor that sits directly downstream of the c1355 circuit under test in the ATPG flow. It accepts the 32-bit primary-output word (G1324..G1355, G1324 = MSB) once per applied test vector and folds each word into a 32-bit multiple-input signature register (MISR). After a programmed number of vectors it presents the final signature and a pass/fail verdict against a golden signature. This replaces dumping every response word to a file.

---
 rtl/c1355_resp_misr.sv | 97 +++++++++
 tb/tb_c1355_resp_misr.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/c1355_resp_misr.sv
// Purpose: folds NUM_VECTORS c1355 response words into a 32-bit MISR and checks the result against golden_sig.
// Latency: LOAD takes one cycle after start, then one word per cycle. done/pass are valid on the edge that takes the last word.
// Backpressure: resp_ready is high only in RUN. It does not depend on resp_valid, so a word offered outside RUN is left unconsumed.
module c1355_resp_misr #(
    parameter int          NUM_VECTORS = 10,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] SEED        = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        resp_ready,
    input  logic [31:0] golden_sig,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [7:0]  count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] sig_q;
    logic [7:0]  count_q;
    logic        pass_q;
    logic        accept;
    logic        last_word;
    logic [31:0] sig_next;

    assign accept    = resp_valid && resp_ready;
    assign last_word = accept && (count_q == LAST_IDX);
    assign sig_next  = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ resp_data;

    always_comb begin
        state_d    = state_q;
        resp_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                resp_ready = 1'b1;
                // The last word wins over a coincident start: start is not looked at in RUN.
                if (last_word) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            count_q <= 8'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == LOAD) begin
                sig_q   <= SEED;
                count_q <= 8'd0;
                pass_q  <= 1'b0;
            end else if (accept) begin
                sig_q   <= sig_next;
                count_q <= count_q + 8'd1;
                // The verdict uses the post-update signature, not the value still held in sig_q.
                if (last_word) pass_q <= (sig_next == golden_sig);
            end
        end
    end

    assign signature = sig_q;
    assign count     = count_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_c1355_resp_misr.sv
// Directed bench for c1355_resp_misr. Four instances with different parameter sets share the reset and the data bus.
module tb_c1355_resp_misr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [3:0]  start_v;
    logic [31:0] gold [4];
    logic        rdy_o  [4];
    logic        busy_o [4];
    logic        done_o [4];
    logic        pass_o [4];
    logic [31:0] sig_o  [4];
    logic [7:0]  cnt_o  [4];

    int total = 0;
    int bad   = 0;
    logic [31:0] sig_run1;

    always #5 clk = ~clk;

    // Instance 0 uses the defaults: 10 vectors and seed FFFFFFFF.
    c1355_resp_misr u_main (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_ready(rdy_o[0]), .golden_sig(gold[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .signature(sig_o[0]), .count(cnt_o[0]));

    c1355_resp_misr #(.NUM_VECTORS(1), .SEED(32'h0)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_ready(rdy_o[1]), .golden_sig(gold[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .signature(sig_o[1]), .count(cnt_o[1]));

    c1355_resp_misr #(.NUM_VECTORS(1)) u_tap (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_ready(rdy_o[2]), .golden_sig(gold[2]),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
        .signature(sig_o[2]), .count(cnt_o[2]));

    c1355_resp_misr #(.NUM_VECTORS(2), .SEED(32'h0)) u_two (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_ready(rdy_o[3]), .golden_sig(gold[3]),
        .busy(busy_o[3]), .done(done_o[3]), .pass(pass_o[3]),
        .signature(sig_o[3]), .count(cnt_o[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ d;
    endfunction

    function automatic logic [31:0] vec(input int set, input int i);
        logic [31:0] k;
        k = 32'(i + 1);
        return (32'h9E3779B9 * k) ^ (set != 0 ? 32'hA5A50F0F : 32'h0);
    endfunction

    function automatic logic [31:0] model_sig(input int set);
        logic [31:0] s;
        s = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) s = misr(s, vec(set, i));
        return s;
    endfunction

    // One full run on u_main. With stall set, resp_valid toggles randomly and start is pulsed
    // during RUN, including on the cycle that carries the last word.
    task automatic run_main(input int set, input bit stall);
        int   idx;
        int   cyc;
        logic acc;
        idx = 0;
        cyc = 0;
        gold[0] = model_sig(set);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        chk("load_busy", 32'(busy_o[0]), 32'd1);
        chk("load_done", 32'(done_o[0]), 32'd0);
        chk("load_rdy", 32'(rdy_o[0]), 32'd0);
        tick();
        chk("run_rdy", 32'(rdy_o[0]), 32'd1);
        chk("run_seed", sig_o[0], 32'hFFFFFFFF);
        chk("run_cnt0", 32'(cnt_o[0]), 32'd0);
        while (idx < 10 && cyc < 300) begin
            resp_data  = vec(set, idx);
            resp_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start_v[0] = stall && ((cyc % 3) == 0 || idx == 9);
            acc = resp_valid && rdy_o[0];
            if (!stall && idx == 9) chk("done_before_last", 32'(done_o[0]), 32'd0);
            tick();
            cyc++;
            if (acc) idx++;
        end
        resp_valid = 1'b0;
        start_v[0] = 1'b0;
        chk("run_words", 32'(idx), 32'd10);
        chk("end_done", 32'(done_o[0]), 32'd1);
        chk("end_busy", 32'(busy_o[0]), 32'd0);
        chk("end_rdy", 32'(rdy_o[0]), 32'd0);
        chk("end_cnt", 32'(cnt_o[0]), 32'd10);
        chk("end_sig", sig_o[0], model_sig(set));
        chk("end_pass", 32'(pass_o[0]), 32'd1);
    endtask

    // Start a small instance and feed it n words, one per cycle.
    task automatic run_small(input int which, input int n, input logic [31:0] d0, input logic [31:0] d1);
        start_v[which] = 1'b1;
        tick();
        start_v[which] = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            resp_data  = (i == 0) ? d0 : d1;
            resp_valid = 1'b1;
            tick();
        end
        resp_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 32'h0;
        start_v    = 4'h0;
        for (int i = 0; i < 4; i++) gold[i] = 32'h0;
        tick();
        tick();
        chk("rst_sig", sig_o[0], 32'hFFFFFFFF);
        chk("rst_cnt", 32'(cnt_o[0]), 32'd0);
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_done", 32'(done_o[0]), 32'd0);
        chk("rst_rdy", 32'(rdy_o[0]), 32'd0);
        chk("rst_pass", 32'(pass_o[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        // Accept 4 words, then assert reset asynchronously in the middle of the cycle.
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            resp_data  = vec(0, i);
            resp_valid = 1'b1;
            tick();
        end
        resp_valid = 1'b0;
        chk("mid_cnt", 32'(cnt_o[0]), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sig", sig_o[0], 32'hFFFFFFFF);
        chk("arst_cnt", 32'(cnt_o[0]), 32'd0);
        chk("arst_busy", 32'(busy_o[0]), 32'd0);
        chk("arst_done", 32'(done_o[0]), 32'd0);
        chk("arst_rdy", 32'(rdy_o[0]), 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // Valid data offered in IDLE must not be taken.
        resp_valid = 1'b1;
        resp_data  = 32'hDEADBEEF;
        tick();
        tick();
        chk("idle_cnt", 32'(cnt_o[0]), 32'd0);
        chk("idle_sig", sig_o[0], 32'hFFFFFFFF);
        resp_valid = 1'b0;

        run_main(0, 1'b0);
        sig_run1 = sig_o[0];

        // DONE holds its outputs while data keeps arriving.
        resp_valid = 1'b1;
        resp_data  = 32'h12345678;
        tick();
        tick();
        resp_valid = 1'b0;
        chk("hold_cnt", 32'(cnt_o[0]), 32'd10);
        chk("hold_sig", sig_o[0], sig_run1);
        chk("hold_done", 32'(done_o[0]), 32'd1);

        // Restart from DONE with the same data, stalled: the result must match the clean run.
        run_main(0, 1'b1);
        chk("stall_same_sig", sig_o[0], sig_run1);

        // Back-to-back run on different data.
        run_main(1, 1'b0);

        gold[1] = 32'h00000001;
        run_small(1, 1, 32'h00000001, 32'h0);
        chk("one_sig", sig_o[1], 32'h00000001);
        chk("one_cnt", 32'(cnt_o[1]), 32'd1);
        chk("one_done", 32'(done_o[1]), 32'd1);
        chk("one_pass", 32'(pass_o[1]), 32'd1);
        gold[1] = 32'h00000002;
        run_small(1, 1, 32'h00000001, 32'h0);
        chk("one_fail_verdict", 32'(pass_o[1]), 32'd0);
        chk("one_sig2", sig_o[1], 32'h00000001);

        gold[2] = 32'hFB3EE249;
        run_small(2, 1, 32'h00000000, 32'h0);
        chk("tap_sig", sig_o[2], 32'hFB3EE249);
        chk("tap_pass", 32'(pass_o[2]), 32'd1);

        gold[3] = 32'h00000002;
        run_small(3, 2, 32'h00000001, 32'h00000000);
        chk("shift_sig", sig_o[3], 32'h00000002);
        chk("shift_cnt", 32'(cnt_o[3]), 32'd2);
        chk("shift_pass", 32'(pass_o[3]), 32'd1);

        // The main instance must not have been disturbed by the other instances' traffic.
        chk("main_untouched", sig_o[0], model_sig(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
